// File: rtl/fetch_target_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_target_queue_pkg
// Brief    : Shared frontend types for the BPU / fetch target queue interface.
// Revision : 1.0
// ============================================================================
package fetch_target_queue_pkg;

    localparam int XLEN      = 32;
    localparam int FTQ_DEPTH = 16;

    typedef logic [XLEN-1:0]                 XDEF;
    typedef logic [$clog2(FTQ_DEPTH)-1:0]    ftqIdx_t;

    typedef enum logic [2:0] {
        BR_NONE     = 3'd0,
        BR_COND     = 3'd1,
        BR_JAL      = 3'd2,
        BR_JALR     = 3'd3,
        BR_CALL     = 3'd4,
        BR_RET      = 3'd5
    } BranchType;

    typedef struct packed {
        XDEF       startAddr;
        XDEF       endAddr;
        XDEF       nextAddr;
        logic      taken;
        XDEF       targetAddr;
        logic      hit_on_ubtb;
        logic      hit_on_ftb;
        BranchType branch_type;
    } BPInfo_t;

    typedef struct packed {
        XDEF       startAddr;
        XDEF       fallthruAddr;
        XDEF       targetAddr;
        logic      taken;
        BranchType branch_type;
    } BPupdateInfo_t;

    // Commit FSM encoding
    localparam logic [0:0] C_FTQ_IDLE = 1'b0;
    localparam logic [0:0] C_FTQ_UPD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fetch_target_queue_storage.sv
`default_nettype none
// ============================================================================
// Module   : ftq_storage
// Brief    : FTQ entry array; one write port, async fetch and commit-head reads.
// Revision : 1.0
// ============================================================================
module ftq_storage
    import fetch_target_queue_pkg::*;
#(
    parameter int DEPTH = FTQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
    input  BPInfo_t                  i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_fetch_idx,
    output BPInfo_t                  o_fetch_data,
    input  logic [$clog2(DEPTH)-1:0] i_head_idx,
    output XDEF                      o_head_start,
    output XDEF                      o_head_end
);

    BPInfo_t mem_q [DEPTH];

    // Entry contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_fetch_data = mem_q[i_fetch_idx];
    assign o_head_start = mem_q[i_head_idx].startAddr;
    assign o_head_end   = mem_q[i_head_idx].endAddr;

endmodule
`default_nettype wire

// File: rtl/fetch_target_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_target_queue
// Brief    : In-order queue of predicted fetch blocks from BPU to fetch/commit.
// Revision : 1.0
// ============================================================================
module fetch_target_queue
    import fetch_target_queue_pkg::*;
#(
    parameter int DEPTH = FTQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_pred_vld,
    input  BPInfo_t       i_pred_ftqInfo,
    output logic          o_ftq_rdy,
    output logic          o_fetch_vld,
    input  logic          i_fetch_rdy,
    output ftqIdx_t       o_fetch_ftqIdx,
    output BPInfo_t       o_fetch_ftqInfo,
    input  logic          i_backend_commit_vld,
    input  logic          i_backend_taken,
    input  XDEF           i_backend_targetAddr,
    input  BranchType     i_backend_branch_type,
    output logic          o_backend_commit_rdy,
    input  logic          i_squash_vld,
    input  ftqIdx_t       i_squash_ftqIdx,
    output logic          o_bpu_commit_vld,
    output BPupdateInfo_t o_BPupdateInfo,
    input  logic          i_bpu_update_finished
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W:0] wptr_q, wptr_d;
    logic [IDX_W:0] fptr_q, fptr_d;
    logic [IDX_W:0] cptr_q, cptr_d;
    logic [0:0]     state_q, state_d;
    BPupdateInfo_t  upd_q, upd_d;

    logic           w_full;
    logic           w_wr_fire;
    logic           w_fetch_fire;
    logic           w_commit_fire;
    logic [IDX_W-1:0] w_sq_off;
    logic [IDX_W:0] w_sq_ptr;
    XDEF            w_head_start;
    XDEF            w_head_end;

    assign w_full = (wptr_q[IDX_W] != cptr_q[IDX_W]) &&
                    (wptr_q[IDX_W-1:0] == cptr_q[IDX_W-1:0]);

    assign o_ftq_rdy            = !w_full && !i_squash_vld;
    assign o_fetch_vld          = (fptr_q != wptr_q);
    assign o_fetch_ftqIdx       = fptr_q[IDX_W-1:0];
    assign o_backend_commit_rdy = (state_q == C_FTQ_IDLE) && (wptr_q != cptr_q) &&
                                  (cptr_q != fptr_q);
    assign o_bpu_commit_vld     = (state_q == C_FTQ_UPD);
    assign o_BPupdateInfo       = upd_q;

    assign w_wr_fire     = i_pred_vld && o_ftq_rdy;
    assign w_fetch_fire  = o_fetch_vld && i_fetch_rdy && !i_squash_vld;
    assign w_commit_fire = i_backend_commit_vld && o_backend_commit_rdy;

    // Rebuild the squashed entry's full pointer (with wrap bit) from its distance to cptr.
    assign w_sq_off = i_squash_ftqIdx - cptr_q[IDX_W-1:0];
    assign w_sq_ptr = cptr_q + {1'b0, w_sq_off} + {{IDX_W{1'b0}}, 1'b1};

    ftq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk          (clk),
        .i_wr_en      (w_wr_fire),
        .i_wr_idx     (wptr_q[IDX_W-1:0]),
        .i_wr_data    (i_pred_ftqInfo),
        .i_fetch_idx  (fptr_q[IDX_W-1:0]),
        .o_fetch_data (o_fetch_ftqInfo),
        .i_head_idx   (cptr_q[IDX_W-1:0]),
        .o_head_start (w_head_start),
        .o_head_end   (w_head_end)
    );

    always_comb begin
        wptr_d = wptr_q;
        fptr_d = fptr_q;
        if (i_squash_vld) begin
            wptr_d = w_sq_ptr;
            fptr_d = w_sq_ptr;
        end else begin
            if (w_wr_fire) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (w_fetch_fire) begin
                fptr_d = fptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cptr_d  = cptr_q;
        upd_d   = upd_q;
        case (state_q)
            C_FTQ_IDLE: begin
                if (w_commit_fire) begin
                    upd_d.startAddr    = w_head_start;
                    upd_d.fallthruAddr = w_head_end;
                    upd_d.targetAddr   = i_backend_targetAddr;
                    upd_d.taken        = i_backend_taken;
                    upd_d.branch_type  = i_backend_branch_type;
                    state_d            = C_FTQ_UPD;
                end
            end
            default: begin
                if (i_bpu_update_finished) begin
                    cptr_d  = cptr_q + 1'b1;
                    state_d = C_FTQ_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            fptr_q  <= '0;
            cptr_q  <= '0;
            state_q <= C_FTQ_IDLE;
            upd_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            fptr_q  <= fptr_d;
            cptr_q  <= cptr_d;
            state_q <= state_d;
            upd_q   <= upd_d;
        end
    end

    a_squash_in_range: assert property (@(posedge clk) disable iff (rst)
        i_squash_vld |-> ({1'b0, w_sq_off} < (wptr_q - cptr_q)));

    a_fallthru_gt_start: assert property (@(posedge clk) disable iff (rst)
        w_commit_fire |-> (w_head_end > w_head_start));

endmodule
`default_nettype wire

// File: tb/tb_fetch_target_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_target_queue
// Brief    : Directed self-checking bench for fetch_target_queue.
// Revision : 1.0
// ============================================================================
module tb_fetch_target_queue;
    import fetch_target_queue_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pred_vld;
    BPInfo_t       i_pred_ftqInfo;
    logic          o_ftq_rdy;
    logic          o_fetch_vld;
    logic          i_fetch_rdy;
    ftqIdx_t       o_fetch_ftqIdx;
    BPInfo_t       o_fetch_ftqInfo;
    logic          i_backend_commit_vld;
    logic          i_backend_taken;
    XDEF           i_backend_targetAddr;
    BranchType     i_backend_branch_type;
    logic          o_backend_commit_rdy;
    logic          i_squash_vld;
    ftqIdx_t       i_squash_ftqIdx;
    logic          o_bpu_commit_vld;
    BPupdateInfo_t o_BPupdateInfo;
    logic          i_bpu_update_finished;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_target_queue #(.DEPTH(16)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_pred_vld            (i_pred_vld),
        .i_pred_ftqInfo        (i_pred_ftqInfo),
        .o_ftq_rdy             (o_ftq_rdy),
        .o_fetch_vld           (o_fetch_vld),
        .i_fetch_rdy           (i_fetch_rdy),
        .o_fetch_ftqIdx        (o_fetch_ftqIdx),
        .o_fetch_ftqInfo       (o_fetch_ftqInfo),
        .i_backend_commit_vld  (i_backend_commit_vld),
        .i_backend_taken       (i_backend_taken),
        .i_backend_targetAddr  (i_backend_targetAddr),
        .i_backend_branch_type (i_backend_branch_type),
        .o_backend_commit_rdy  (o_backend_commit_rdy),
        .i_squash_vld          (i_squash_vld),
        .i_squash_ftqIdx       (i_squash_ftqIdx),
        .o_bpu_commit_vld      (o_bpu_commit_vld),
        .o_BPupdateInfo        (o_BPupdateInfo),
        .i_bpu_update_finished (i_bpu_update_finished)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic BPInfo_t mk(input logic [31:0] addr);
        BPInfo_t b;
        b             = '0;
        b.startAddr   = addr;
        b.endAddr     = addr + 32'h10;
        b.nextAddr    = addr + 32'h10;
        b.branch_type = BR_NONE;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_pred_vld            = 1'b0;
        i_pred_ftqInfo        = '0;
        i_fetch_rdy           = 1'b0;
        i_backend_commit_vld  = 1'b0;
        i_backend_taken       = 1'b0;
        i_backend_targetAddr  = '0;
        i_backend_branch_type = BR_NONE;
        i_squash_vld          = 1'b0;
        i_squash_ftqIdx       = '0;
        i_bpu_update_finished = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int written;
        int commits;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("rst_ftq_rdy",    o_ftq_rdy, 1);
        check("rst_fetch_vld",  o_fetch_vld, 0);
        check("rst_commit_rdy", o_backend_commit_rdy, 0);
        check("rst_bpu_vld",    o_bpu_commit_vld, 0);
        check("rst_updinfo",    o_BPupdateInfo, 0);
        rst = 1'b0;
        tick();

        // Fill to full with fetch stalled; the 17th write must be refused.
        for (int i = 0; i < 16; i++) begin
            i_pred_vld     = 1'b1;
            i_pred_ftqInfo = mk(32'h1000_0000 + 32'(i) * 32'h20);
            if (i == 15) check("fill_rdy_before_last", o_ftq_rdy, 1);
            tick();
        end
        i_pred_ftqInfo = mk(32'hDEAD_0000);
        #1;
        check("full_rdy_low", o_ftq_rdy, 0);
        check("full_wptr",    dut.wptr_q, 5'b10000);
        tick();
        i_pred_vld = 1'b0;
        check("full_wptr_hold",  dut.wptr_q, 5'b10000);
        check("full_head_idx",   o_fetch_ftqIdx, 0);
        check("full_head_start", o_fetch_ftqInfo.startAddr, 32'h1000_0000);

        // Write then fetch.
        do_reset();
        i_pred_vld     = 1'b1;
        i_pred_ftqInfo = mk(32'h8000_0000);
        tick();
        i_pred_vld = 1'b0;
        check("wf_fetch_vld", o_fetch_vld, 1);
        check("wf_idx",       o_fetch_ftqIdx, 0);
        check("wf_start",     o_fetch_ftqInfo.startAddr, 32'h8000_0000);
        check("wf_end",       o_fetch_ftqInfo.endAddr, 32'h8000_0010);
        check("wf_commit_rdy_unfetched", o_backend_commit_rdy, 0);
        i_fetch_rdy = 1'b1;
        tick();
        i_fetch_rdy = 1'b0;
        check("wf_fetch_vld_after", o_fetch_vld, 0);

        // Commit round trip.
        check("cm_commit_rdy", o_backend_commit_rdy, 1);
        i_backend_commit_vld  = 1'b1;
        i_backend_taken       = 1'b1;
        i_backend_targetAddr  = 32'h8000_0100;
        i_backend_branch_type = BR_JAL;
        tick();
        idle_inputs();
        check("cm_bpu_vld",   o_bpu_commit_vld, 1);
        check("cm_start",     o_BPupdateInfo.startAddr, 32'h8000_0000);
        check("cm_fallthru",  o_BPupdateInfo.fallthruAddr, 32'h8000_0010);
        check("cm_target",    o_BPupdateInfo.targetAddr, 32'h8000_0100);
        check("cm_taken",     o_BPupdateInfo.taken, 1);
        check("cm_btype",     o_BPupdateInfo.branch_type, BR_JAL);
        check("cm_rdy_in_upd", o_backend_commit_rdy, 0);
        tick();
        check("cm_hold_vld",   o_bpu_commit_vld, 1);
        check("cm_hold_start", o_BPupdateInfo.startAddr, 32'h8000_0000);
        i_bpu_update_finished = 1'b1;
        tick();
        i_bpu_update_finished = 1'b0;
        check("cm_done_vld", o_bpu_commit_vld, 0);
        check("cm_cptr",     dut.cptr_q, 5'd1);

        // Squash: 8 written, 5 fetched, squash idx 3 alongside a prediction.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            i_pred_vld     = 1'b1;
            i_pred_ftqInfo = mk(32'h2000_0000 + 32'(i) * 32'h20);
            tick();
        end
        i_pred_vld  = 1'b0;
        i_fetch_rdy = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("sq_pre_fidx", o_fetch_ftqIdx, 5);
        i_squash_vld    = 1'b1;
        i_squash_ftqIdx = 4'd3;
        i_pred_vld      = 1'b1;
        i_pred_ftqInfo  = mk(32'h3000_0000);
        #1;
        check("sq_rdy_low", o_ftq_rdy, 0);
        tick();
        idle_inputs();
        check("sq_wptr",      dut.wptr_q, 5'd4);
        check("sq_fptr",      dut.fptr_q, 5'd4);
        check("sq_cptr",      dut.cptr_q, 5'd0);
        check("sq_fetch_vld", o_fetch_vld, 0);
        i_pred_vld     = 1'b1;
        i_pred_ftqInfo = mk(32'h3100_0000);
        tick();
        i_pred_vld = 1'b0;
        check("sq_new_idx",   o_fetch_ftqIdx, 4);
        check("sq_new_start", o_fetch_ftqInfo.startAddr, 32'h3100_0000);

        // Wrap-around: 40 blocks with continuous fetch and commit.
        do_reset();
        written = 0;
        commits = 0;
        for (int cyc = 0; cyc < 400 && commits < 40; cyc++) begin
            i_pred_vld            = (written < 40);
            i_pred_ftqInfo        = mk(32'h4000_0000 + 32'(written) * 32'h20);
            i_fetch_rdy           = 1'b1;
            i_backend_commit_vld  = 1'b1;
            i_bpu_update_finished = 1'b1;
            #1;
            if (o_bpu_commit_vld) begin
                check("wrap_order", o_BPupdateInfo.startAddr,
                      32'h4000_0000 + 32'(commits) * 32'h20);
                commits++;
            end
            if (i_pred_vld && o_ftq_rdy) written++;
            tick();
        end
        idle_inputs();
        check("wrap_commits", commits, 40);
        check("wrap_wptr",    dut.wptr_q, 5'd8);
        check("wrap_cptr",    dut.cptr_q, 5'd8);

        // Reset while an update is pending.
        i_pred_vld     = 1'b1;
        i_pred_ftqInfo = mk(32'h9000_0000);
        tick();
        i_pred_vld  = 1'b0;
        i_fetch_rdy = 1'b1;
        tick();
        i_fetch_rdy          = 1'b0;
        i_backend_commit_vld = 1'b1;
        tick();
        i_backend_commit_vld = 1'b0;
        check("rm_in_upd", o_bpu_commit_vld, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rm_bpu_vld", o_bpu_commit_vld, 0);
        check("rm_wptr",    dut.wptr_q, 5'd0);
        check("rm_fptr",    dut.fptr_q, 5'd0);
        check("rm_cptr",    dut.cptr_q, 5'd0);
        check("rm_updinfo", o_BPupdateInfo, 0);
        check("rm_ftq_rdy", o_ftq_rdy, 1);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
